// File: rtl/gcn_transform_ctrl.sv
// Sequencer for the GCN transformation stage FM_WM = FM x WM.
// Walks three nested counters (k innermost dot-product index, c weight column,
// r feature row), issues paired feature/weight reads, steers the MAC
// accumulate/clear controls one cycle behind the reads (memory latency), and
// hands each finished dot product to the result buffer.
//
// Result handshake: res_wr_en is a valid that, once raised, stays high with
// res_row/res_col held stable until a cycle in which res_wr_ready is also high;
// that cycle is the transfer. No other condition completes or withdraws the
// request except abort or reset.
module gcn_transform_ctrl #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 96,
  parameter int WEIGHT_COLS  = 3,
  localparam int FR_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  localparam int K_W  = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1,
  localparam int WC_W = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            feat_rd_en,
  output logic [FR_W-1:0] feat_row_addr,
  output logic [K_W-1:0]  feat_col_addr,
  output logic            wgt_rd_en,
  output logic [K_W-1:0]  wgt_row_addr,
  output logic [WC_W-1:0] wgt_col_addr,
  output logic            mac_en,
  output logic            mac_clear,
  output logic            res_wr_en,
  input  logic            res_wr_ready,
  output logic [FR_W-1:0] res_row,
  output logic [WC_W-1:0] res_col,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Last legal value of each counter; counters wrap here and never exceed it.
  localparam logic [FR_W-1:0] R_LAST = FR_W'(FEATURE_ROWS - 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(FEATURE_COLS - 1);
  localparam logic [WC_W-1:0] C_LAST = WC_W'(WEIGHT_COLS - 1);

  state_e          state_q, state_d;
  logic [FR_W-1:0] r_q, r_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [WC_W-1:0] c_q, c_d;
  // MAC controls are the read strobe delayed by the one-cycle memory latency.
  logic            mac_en_q, mac_en_d;
  logic            mac_clear_q, mac_clear_d;

  // State, counters and the delayed MAC controls; reset discards any pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      k_q         <= '0;
      c_q         <= '0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      c_q         <= c_d;
      mac_en_q    <= mac_en_d;
      mac_clear_q <= mac_clear_d;
    end
  end

  // Next-state, counter stepping and the Moore-style strobes.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    k_d         = k_q;
    c_d         = c_q;
    mac_en_d    = 1'b0;
    mac_clear_d = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    feat_rd_en  = 1'b0;
    res_wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start that arrives together with abort is dropped.
        if (start && !abort) begin
          state_d = ST_ISSUE;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end

      ST_ISSUE: begin
        busy        = 1'b1;
        feat_rd_en  = 1'b1;
        mac_en_d    = 1'b1;
        // First read of a dot product restarts the accumulator.
        mac_clear_d = (k_q == '0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      ST_DRAIN: begin
        // Lets the final read's data pass through the MAC before the write.
        busy    = 1'b1;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        busy      = 1'b1;
        res_wr_en = 1'b1;
        if (res_wr_ready) begin
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = ST_DONE;
            end else begin
              r_d     = r_q + FR_W'(1);
              state_d = ST_ISSUE;
            end
          end else begin
            c_d     = c_q + WC_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything outside IDLE: back to IDLE with clean
    // counters, the in-flight MAC strobe squashed, and no done pulse.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      r_d         = '0;
      k_d         = '0;
      c_d         = '0;
      mac_en_d    = 1'b0;
      mac_clear_d = 1'b0;
      done        = 1'b0;
    end
  end

  // Addresses follow the counters directly; they only matter under their strobe.
  always_comb begin
    wgt_rd_en     = feat_rd_en;
    feat_row_addr = r_q;
    feat_col_addr = k_q;
    wgt_row_addr  = k_q;
    wgt_col_addr  = c_q;
    res_row       = r_q;
    res_col       = c_q;
    mac_en        = mac_en_q;
    mac_clear     = mac_clear_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_gcn_transform_ctrl.sv
// Bench for gcn_transform_ctrl: a small instance (2 rows, K=3, 2 cols) with
// memory and MAC models whose results are checked against FM x WM computed
// directly, plus a default-size instance for order/count/latency.
module tb_gcn_transform_ctrl;

  localparam int AR = 2, AK = 3, AC = 2;
  localparam int BR = 6, BK = 96, BC = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic       a_start, a_abort, a_ready;
  logic       a_busy, a_done, a_feat_rd_en, a_wgt_rd_en, a_mac_en, a_mac_clear, a_res_wr_en;
  logic [0:0] a_feat_row_addr, a_wgt_col_addr, a_res_row, a_res_col;
  logic [1:0] a_feat_col_addr, a_wgt_row_addr;
  logic [2:0] a_dbg;
  logic [14:0] a_outs;

  gcn_transform_ctrl #(.FEATURE_ROWS(AR), .FEATURE_COLS(AK), .WEIGHT_COLS(AC)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done),
    .feat_rd_en(a_feat_rd_en), .feat_row_addr(a_feat_row_addr), .feat_col_addr(a_feat_col_addr),
    .wgt_rd_en(a_wgt_rd_en), .wgt_row_addr(a_wgt_row_addr), .wgt_col_addr(a_wgt_col_addr),
    .mac_en(a_mac_en), .mac_clear(a_mac_clear),
    .res_wr_en(a_res_wr_en), .res_wr_ready(a_ready), .res_row(a_res_row), .res_col(a_res_col),
    .dbg_state(a_dbg)
  );

  assign a_outs = {a_busy, a_done, a_feat_rd_en, a_feat_row_addr, a_feat_col_addr, a_wgt_rd_en,
                   a_wgt_row_addr, a_wgt_col_addr, a_mac_en, a_mac_clear, a_res_wr_en,
                   a_res_row, a_res_col};

  // ---------------- default-size instance ----------------
  logic       b_start, b_abort, b_ready;
  logic       b_busy, b_done, b_feat_rd_en, b_wgt_rd_en, b_mac_en, b_mac_clear, b_res_wr_en;
  logic [2:0] b_feat_row_addr, b_res_row;
  logic [6:0] b_feat_col_addr, b_wgt_row_addr;
  logic [1:0] b_wgt_col_addr, b_res_col;
  logic [2:0] b_dbg;
  logic [30:0] b_outs;

  gcn_transform_ctrl dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done),
    .feat_rd_en(b_feat_rd_en), .feat_row_addr(b_feat_row_addr), .feat_col_addr(b_feat_col_addr),
    .wgt_rd_en(b_wgt_rd_en), .wgt_row_addr(b_wgt_row_addr), .wgt_col_addr(b_wgt_col_addr),
    .mac_en(b_mac_en), .mac_clear(b_mac_clear),
    .res_wr_en(b_res_wr_en), .res_wr_ready(b_ready), .res_row(b_res_row), .res_col(b_res_col),
    .dbg_state(b_dbg)
  );

  assign b_outs = {b_busy, b_done, b_feat_rd_en, b_feat_row_addr, b_feat_col_addr, b_wgt_rd_en,
                   b_wgt_row_addr, b_wgt_col_addr, b_mac_en, b_mac_clear, b_res_wr_en,
                   b_res_row, b_res_col};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q_a[$];   // {row[7:0], col[7:0], value[15:0]}
  logic [31:0] exp_q_b[$];   // {row[7:0], col[7:0], 16'h0}
  int fm[AR][AK];
  int wm[AK][AC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    total++;
    assert (cond) else begin
      bad++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  function automatic int dot(input int r, input int c);
    int s = 0;
    for (int k = 0; k < AK; k++) s += fm[r][k] * wm[k][c];
    return s;
  endfunction

  task automatic push_a();
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++)
        exp_q_a.push_back({8'(r), 8'(c), 16'(dot(r, c))});
  endtask

  task automatic push_b();
    for (int r = 0; r < BR; r++)
      for (int c = 0; c < BC; c++)
        exp_q_b.push_back({8'(r), 8'(c), 16'h0});
  endtask

  // ---------------- memory + MAC model for the small instance ----------------
  int fd, wd, acc;
  always @(posedge clk) begin
    if (a_feat_rd_en) begin
      fd <= fm[a_feat_row_addr][a_feat_col_addr];
      wd <= wm[a_wgt_row_addr][a_wgt_col_addr];
    end
    if (a_mac_en) acc <= a_mac_clear ? fd * wd : acc + fd * wd;
  end

  // ---------------- monitor, small instance ----------------
  int   exp_k = 0;
  logic prev_rd = 1'b0, prev_clr = 1'b0;
  int   a_done_cnt = 0;
  logic [31:0] ea;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_k    = 0;
      prev_rd  = 1'b0;
      prev_clr = 1'b0;
    end else begin
      chk("a_mac_en_lag", 32'(a_mac_en), 32'(prev_rd));
      chk("a_mac_clear_lag", 32'(a_mac_clear), 32'(prev_clr));
      if (a_feat_rd_en) begin
        check_true("a_rd_pending", exp_q_a.size() != 0);
        if (exp_q_a.size() != 0) begin
          ea = exp_q_a[0];
          chk("a_rd_row", 32'(a_feat_row_addr), 32'(ea[31:24]));
          chk("a_rd_wcol", 32'(a_wgt_col_addr), 32'(ea[23:16]));
        end
        chk("a_rd_k", 32'(a_feat_col_addr), exp_k);
        chk("a_rd_wk", 32'(a_wgt_row_addr), exp_k);
        chk("a_wgt_rd_en", 32'(a_wgt_rd_en), 32'd1);
        chk("a_rd_no_wr", 32'(a_res_wr_en), 32'd0);
      end
      prev_rd  = a_feat_rd_en && !a_abort;
      prev_clr = a_feat_rd_en && (exp_k == 0) && !a_abort;
      if (a_abort) exp_k = 0;
      else if (a_feat_rd_en) exp_k = (exp_k == AK - 1) ? 0 : exp_k + 1;
      if (a_res_wr_en && a_ready && !a_abort) begin
        check_true("a_wr_pending", exp_q_a.size() != 0);
        if (exp_q_a.size() != 0) begin
          ea = exp_q_a.pop_front();
          chk("a_wr_row", 32'(a_res_row), 32'(ea[31:24]));
          chk("a_wr_col", 32'(a_res_col), 32'(ea[23:16]));
          chk("a_wr_value", acc, 32'(ea[15:0]));
        end
      end
      if (a_done) a_done_cnt++;
    end
  end

  // ---------------- monitor, default instance ----------------
  int b_done_cnt = 0, b_wr_cnt = 0;
  logic [31:0] eb;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_res_wr_en && b_ready) begin
        b_wr_cnt++;
        check_true("b_wr_pending", exp_q_b.size() != 0);
        if (exp_q_b.size() != 0) begin
          eb = exp_q_b.pop_front();
          chk("b_wr_row", 32'(b_res_row), 32'(eb[31:24]));
          chk("b_wr_col", 32'(b_res_col), 32'(eb[23:16]));
        end
      end
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Raise start (caller sits just after a posedge), then count cycles from
  // the sampling edge until done is seen, and how many of them had busy high.
  task automatic run_count(input bit sel, input int bound, output int cyc, output int bsy);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    cyc = 0;
    bsy = 0;
    while (cyc < bound) begin
      @(posedge clk);
      cyc++;
      #2;
      a_start = 1'b0;
      b_start = 1'b0;
      @(negedge clk);
      if (sel ? b_busy : a_busy) bsy++;
      if (sel ? b_done : a_done) break;
    end
  endtask

  task automatic wait_wr_a(input int row, input int col, output bit found);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (a_res_wr_en && int'(a_res_row) == row && int'(a_res_col) == col) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rd_a(input int row, input int col, input int k, output bit found);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (a_feat_rd_en && int'(a_feat_row_addr) == row && int'(a_wgt_col_addr) == col &&
          int'(a_feat_col_addr) == k) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done_a(input int base);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (a_done_cnt != base) break;
    end
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog expired before test end");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, bsy, d0, w0;
    bit found;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
    for (int r = 0; r < AR; r++)
      for (int k = 0; k < AK; k++) fm[r][k] = int'($urandom_range(1, 15));
    for (int k = 0; k < AK; k++)
      for (int c = 0; c < AC; c++) wm[k][c] = int'($urandom_range(1, 15));

    // Reset state
    @(negedge clk);
    chk("a_reset_outs", 32'(a_outs), 32'd0);
    chk("a_reset_state", 32'(a_dbg), 32'd0);
    chk("b_reset_outs", 32'(b_outs), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1/2: full pass, ready always 1
    push_a();
    run_count(1'b0, 200, cyc, bsy);
    chk("t1_cycles", cyc, 32'd21);
    chk("t1_busy_cycles", bsy, 32'd20);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(a_done), 32'd0);
    chk("t1_idle_state", 32'(a_dbg), 32'd0);
    check_true("t1_all_written", exp_q_a.size() == 0);
    step();

    // 3: back-pressure on write (0,1)
    push_a();
    d0 = a_done_cnt;
    pulse_start_a();
    wait_wr_a(0, 0, found);
    check_true("t3_wr00_seen", found);
    step();
    a_ready = 1'b0;
    wait_wr_a(0, 1, found);
    check_true("t3_wr01_seen", found);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_wr_en", 32'(a_res_wr_en), 32'd1);
      chk("t3_hold_row", 32'(a_res_row), 32'd0);
      chk("t3_hold_col", 32'(a_res_col), 32'd1);
      chk("t3_no_read", 32'(a_feat_rd_en), 32'd0);
      @(negedge clk);
    end
    step();
    a_ready = 1'b1;
    wait_done_a(d0);
    chk("t3_done_count", a_done_cnt, d0 + 1);
    check_true("t3_all_written", exp_q_a.size() == 0);
    step();

    // 4: abort in ISSUE of output (1,0) at k=1
    push_a();
    pulse_start_a();
    wait_rd_a(1, 0, 0, found);
    check_true("t4_rd10_seen", found);
    step();
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    @(negedge clk);
    chk("t4_state_idle", 32'(a_dbg), 32'd0);
    chk("t4_busy", 32'(a_busy), 32'd0);
    chk("t4_rd_en", 32'(a_feat_rd_en), 32'd0);
    chk("t4_mac_en", 32'(a_mac_en), 32'd0);
    chk("t4_mac_clear", 32'(a_mac_clear), 32'd0);
    chk("t4_wr_en", 32'(a_res_wr_en), 32'd0);
    exp_q_a.delete();
    d0 = a_done_cnt;
    repeat (4) @(negedge clk);
    chk("t4_no_done", a_done_cnt, d0);
    step();
    push_a();
    run_count(1'b0, 200, cyc, bsy);
    chk("t4_restart_cycles", cyc, 32'd21);
    check_true("t4_restart_written", exp_q_a.size() == 0);
    step();

    // 5: start while busy, start in DONE, start+abort in IDLE, reset mid-WRITE
    push_a();
    d0 = a_done_cnt;
    pulse_start_a();
    repeat (3) step();
    pulse_start_a();
    wait_wr_a(1, 1, found);
    check_true("t5_wr11_seen", found);
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    @(negedge clk);
    chk("t5_done_start_ignored", 32'(a_dbg), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_still_idle", 32'(a_busy), 32'd0);
    chk("t5_done_count", a_done_cnt, d0 + 1);
    check_true("t5_all_written", exp_q_a.size() == 0);
    step();
    a_start = 1'b1;
    a_abort = 1'b1;
    step();
    a_start = 1'b0;
    a_abort = 1'b0;
    @(negedge clk);
    chk("t5_start_abort_idle", 32'(a_dbg), 32'd0);
    chk("t5_start_abort_busy", 32'(a_busy), 32'd0);
    step();
    a_ready = 1'b0;
    push_a();
    pulse_start_a();
    wait_wr_a(0, 0, found);
    check_true("t5_rst_wr_seen", found);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_reset_outs", 32'(a_outs), 32'd0);
    chk("t5_async_reset_state", 32'(a_dbg), 32'd0);
    exp_q_a.delete();
    step();
    step();
    rst_n = 1'b1;
    a_ready = 1'b1;
    step();

    // 6: default size, ready always 1, then random ready
    push_b();
    run_count(1'b1, 3000, cyc, bsy);
    chk("t6_cycles", cyc, 32'd1765);
    chk("t6_busy_cycles", bsy, 32'd1764);
    check_true("t6_all_written", exp_q_b.size() == 0);
    step();
    push_b();
    d0 = b_done_cnt;
    w0 = b_wr_cnt;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      b_ready = 1'($urandom_range(0, 1));
      step();
      if (b_done_cnt != d0) break;
    end
    b_ready = 1'b1;
    repeat (4) step();
    chk("t6_rand_done_once", b_done_cnt, d0 + 1);
    chk("t6_rand_writes", b_wr_cnt - w0, 32'd18);
    check_true("t6_rand_all_written", exp_q_b.size() == 0);
    chk("t6_rand_idle", 32'(b_dbg), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
